// File: rtl/multicycle_memory_interface_pkg.sv
// multicycle_memory_interface_pkg: format codes, error causes and FSM states for the data-side bus adapter
package multicycle_memory_interface_pkg;
  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;
  localparam logic [1:0] ERR_OK         = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;
  localparam logic [1:0] ERR_FORMAT     = 2'b11;
  typedef enum logic [1:0] {IDLE, ACCESS_LO, ACCESS_HI, RESPOND} state_t;
  function automatic logic fmt_legal(input logic [2:0] f);
    return f inside {FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU};
  endfunction
  function automatic logic [2:0] fmt_size(input logic [2:0] f);
    return f[1] ? 3'd4 : f[0] ? 3'd2 : 3'd1;
  endfunction
  function automatic logic [3:0] size_mask(input logic [2:0] f);
    return f[1] ? 4'b1111 : f[0] ? 4'b0011 : 4'b0001;
  endfunction
endpackage

// File: rtl/multicycle_memory_interface_if.sv
// multicycle_memory_interface_if: core load/store port and system data bus bundled together
interface multicycle_memory_interface_if;
  logic        core_request, core_write, core_busy, core_done;
  logic [2:0]  core_format;
  logic [31:0] core_address, core_write_data, core_read_data;
  logic [1:0]  core_error_cause;
  logic [31:0] bus_address, bus_read_data, bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable, bus_ready;
  modport slave (
    input  core_request, core_write, core_format, core_address, core_write_data, bus_read_data, bus_ready,
    output core_read_data, core_busy, core_done, core_error_cause,
           bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable
  );
  modport master (
    output core_request, core_write, core_format, core_address, core_write_data, bus_read_data, bus_ready,
    input  core_read_data, core_busy, core_done, core_error_cause,
           bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable
  );
endinterface

// File: rtl/multicycle_memory_interface_memory_lane_aligner.sv
// memory_lane_aligner: lane enables and write data for both halves of an access, plus load assembly/extension
module memory_lane_aligner
  import multicycle_memory_interface_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] rdata,
  output logic        crosses
);
  logic [7:0]  be_wide;
  logic [63:0] wd_wide, pair;
  logic [31:0] sh;
  // shifting into a double-width vector yields the lo half and the spill into the hi word at once
  always_comb begin
    be_wide = {4'b0000, size_mask(fmt)} << off;
    wd_wide = {32'b0, wdata} << {off, 3'b000};
    pair    = {hi, lo} >> {off, 3'b000};
    sh      = pair[31:0];
    be_lo   = be_wide[3:0];
    be_hi   = be_wide[7:4];
    wd_lo   = wd_wide[31:0];
    wd_hi   = wd_wide[63:32];
    rdata   = fmt[1] ? sh
            : fmt[0] ? {{16{sh[15] & ~fmt[2]}}, sh[15:0]}
            : {{24{sh[7] & ~fmt[2]}}, sh[7:0]};
    crosses = ({1'b0, off} + fmt_size(fmt)) > 3'd4;
  end
endmodule

// File: rtl/multicycle_memory_interface.sv
// multicycle_memory_interface: variable-latency data bus adapter with split misaligned accesses and bus timeout
module multicycle_memory_interface
  import multicycle_memory_interface_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int TIMEOUT_CYCLES   = 15
) (
  input logic clock,
  input logic reset,
  multicycle_memory_interface_if.slave mif
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, lo_q, rdata_q, rd_lo;
  logic [2:0]  fmt_q;
  logic        wr_q, acc, expire, req_cross, crosses;
  logic [1:0]  cause_q, cause_n;
  logic [CW-1:0] cnt;
  logic [3:0]  be_lo, be_hi;
  logic [31:0] wd_lo, wd_hi, rd;
  assign acc       = state == ACCESS_LO || state == ACCESS_HI;
  assign expire    = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign req_cross = ({1'b0, mif.core_address[1:0]} + fmt_size(mif.core_format)) > 3'd4;
  assign rd_lo     = state == ACCESS_LO ? mif.bus_read_data : lo_q;
  memory_lane_aligner u_aligner (
    .fmt(fmt_q), .off(addr_q[1:0]), .wdata(wdata_q), .lo(rd_lo), .hi(mif.bus_read_data),
    .be_lo(be_lo), .be_hi(be_hi), .wd_lo(wd_lo), .wd_hi(wd_hi), .rdata(rd), .crosses(crosses)
  );
  always_comb begin
    state_n = state;
    cause_n = cause_q;
    unique case (state)
      IDLE: if (mif.core_request) begin
        cause_n = !fmt_legal(mif.core_format) ? ERR_FORMAT
                : (req_cross && !ALLOW_MISALIGNED) ? ERR_MISALIGNED : ERR_OK;
        state_n = cause_n == ERR_OK ? ACCESS_LO : RESPOND;
      end
      ACCESS_LO: if (mif.bus_ready) state_n = crosses ? ACCESS_HI : RESPOND;
        else if (expire) begin
          state_n = RESPOND;
          cause_n = ERR_TIMEOUT;
        end
      ACCESS_HI: if (mif.bus_ready || expire) begin
        state_n = RESPOND;
        cause_n = mif.bus_ready ? ERR_OK : ERR_TIMEOUT;
      end
      RESPOND: state_n = IDLE;
    endcase
  end
  // bus side is driven purely from state and latched request, never from live core inputs
  assign mif.bus_address      = acc ? {addr_q[31:2], 2'b00} + (state == ACCESS_HI ? 32'd4 : 32'd0) : '0;
  assign mif.bus_byte_enable  = acc ? (state == ACCESS_HI ? be_hi : be_lo) : '0;
  assign mif.bus_write_data   = acc && wr_q ? (state == ACCESS_HI ? wd_hi : wd_lo) : '0;
  assign mif.bus_read_enable  = acc && !wr_q;
  assign mif.bus_write_enable = acc && wr_q;
  assign mif.core_busy        = state != IDLE;
  assign mif.core_done        = state == RESPOND;
  assign mif.core_read_data   = rdata_q;
  assign mif.core_error_cause = cause_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      fmt_q   <= '0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      cause_q <= ERR_OK;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
      cnt     <= state_n != state ? '0 : cnt + 1'b1;
      if (state == IDLE && mif.core_request) begin
        addr_q  <= mif.core_address;
        wdata_q <= mif.core_write_data;
        fmt_q   <= mif.core_format;
        wr_q    <= mif.core_write;
      end
      if (state == ACCESS_LO && mif.bus_ready) lo_q <= mif.bus_read_data;
      if (acc && mif.bus_ready && state_n == RESPOND && !wr_q) rdata_q <= rd;
    end
  end
endmodule

// File: tb/tb_multicycle_memory_interface.sv
// tb_multicycle_memory_interface: directed transactions checked every cycle against a byte-level transaction model
module tb_multicycle_memory_interface;
  import multicycle_memory_interface_pkg::*;
  localparam int T = 15;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  multicycle_memory_interface_if a_if();
  multicycle_memory_interface_if n_if();
  multicycle_memory_interface #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(T)) dut_a (.clock(clk), .reset(rst), .mif(a_if));
  multicycle_memory_interface #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(T)) dut_n (.clock(clk), .reset(rst), .mif(n_if));
  typedef struct packed {
    logic req, wr; logic [2:0] fmt; logic [31:0] addr, wdata; logic rdy; logic [31:0] bus_rd;
    logic busy, done, re, we; logic [31:0] baddr; logic [3:0] be; logic [31:0] wd; logic [1:0] cause; logic [31:0] rd;
  } cyc_t;
  typedef struct packed { logic [31:0] a; logic [3:0] be; logic [31:0] wd; } beat_t;
  cyc_t q[$];
  cyc_t cur;
  bit cur_valid = 1'b0;
  logic [31:0] model_rd = '0;
  int checks = 0, errors = 0, n_re = 0, n_done = 0;
  logic [1:0] last_cause = '0;
  beat_t beats[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic cyc_t idle();
    cyc_t c;
    c = '0;
    c.rd = model_rd;
    return c;
  endfunction

  // expected cycle-by-cycle behaviour of one transaction, built from byte positions rather than shifts
  task automatic plan(input logic wr, input logic [2:0] fmt, input logic [31:0] addr, input logic [31:0] wd_in,
                      input logic [31:0] blo, input logic [31:0] bhi, input int wlo, input int whi);
    int size, off, w;
    bit legal, split;
    logic [3:0] be [2];
    logic [31:0] wd [2];
    logic [31:0] bw [2];
    logic [31:0] val;
    logic [1:0] cause;
    cyc_t c;
    legal = fmt inside {FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU};
    size = fmt == FMT_W ? 4 : (fmt == FMT_H || fmt == FMT_HU) ? 2 : 1;
    off = int'(addr[1:0]);
    split = off + size > 4;
    bw[0] = blo; bw[1] = bhi; be[0] = '0; be[1] = '0; wd[0] = '0; wd[1] = '0; val = '0;
    for (int i = 0; i < 4; i++) wd[(off + i) / 4][8 * ((off + i) % 4) +: 8] = wd_in[8 * i +: 8];
    for (int i = 0; i < size; i++) begin
      be[(off + i) / 4][(off + i) % 4] = 1'b1;
      val[8 * i +: 8] = bw[(off + i) / 4][8 * ((off + i) % 4) +: 8];
    end
    if (fmt == FMT_B && val[7]) val[31:8] = '1;
    if (fmt == FMT_H && val[15]) val[31:16] = '1;
    c = idle(); c.req = 1'b1; c.wr = wr; c.fmt = fmt; c.addr = addr; c.wdata = wd_in;
    q.push_back(c);
    cause = legal ? ERR_OK : ERR_FORMAT;
    if (legal) for (int b = 0; b < (split ? 2 : 1); b++) begin
      w = b != 0 ? whi : wlo;
      for (int k = 0; k <= w && k < T; k++) begin
        c = idle(); c.busy = 1'b1; c.re = !wr; c.we = wr;
        c.baddr = {addr[31:2], 2'b00} + 32'(4 * b);
        c.be = be[b]; c.wd = wr ? wd[b] : '0; c.rdy = k == w; c.bus_rd = bw[b];
        q.push_back(c);
      end
      if (w >= T) begin
        cause = ERR_TIMEOUT;
        break;
      end
    end
    if (cause == ERR_OK && !wr) model_rd = val;
    c = idle(); c.busy = 1'b1; c.done = 1'b1; c.cause = cause;
    q.push_back(c);
    q.push_back(idle());
  endtask

  task automatic drive(input cyc_t c);
    a_if.core_request = c.req; a_if.core_write = c.wr; a_if.core_format = c.fmt;
    a_if.core_address = c.addr; a_if.core_write_data = c.wdata;
    a_if.bus_ready = c.rdy; a_if.bus_read_data = c.bus_rd;
    cur = c;
    cur_valid = 1'b1;
  endtask

  task automatic run(input int n);
    while (q.size() != 0 && n != 0) begin
      @(negedge clk);
      drive(q.pop_front());
      n--;
    end
    #3;
  endtask

  task automatic clear();
    n_re = 0; n_done = 0; last_cause = '0; beats.delete();
  endtask

  always @(negedge clk) begin
    #2;
    if (cur_valid) begin
      chk("busy", 32'(a_if.core_busy), 32'(cur.busy));
      chk("done", 32'(a_if.core_done), 32'(cur.done));
      chk("read_en", 32'(a_if.bus_read_enable), 32'(cur.re));
      chk("write_en", 32'(a_if.bus_write_enable), 32'(cur.we));
      chk("bus_addr", a_if.bus_address, cur.baddr);
      chk("byte_en", 32'(a_if.bus_byte_enable), 32'(cur.be));
      chk("bus_wdata", a_if.bus_write_data, cur.wd);
      chk("read_data", a_if.core_read_data, cur.rd);
      if (cur.done) chk("cause", 32'(a_if.core_error_cause), 32'(cur.cause));
    end
    if (a_if.bus_read_enable) n_re++;
    if (a_if.core_done) begin
      n_done++;
      last_cause = a_if.core_error_cause;
    end
    if ((a_if.bus_read_enable || a_if.bus_write_enable) && a_if.bus_ready)
      beats.push_back({a_if.bus_address, a_if.bus_byte_enable, a_if.bus_write_data});
  end

  initial begin
    n_if.core_request = 1'b0; n_if.core_write = 1'b0; n_if.core_format = FMT_W;
    n_if.core_address = '0; n_if.core_write_data = '0; n_if.bus_read_data = '0; n_if.bus_ready = 1'b0;
    drive(idle());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear(); plan(1'b0, FMT_W, 32'h100, '0, 32'hDEADBEEF, '0, 0, 0); run(-1);
    chk("lw_rd", a_if.core_read_data, 32'hDEADBEEF);
    chk("lw_done_count", 32'(n_done), 32'd1);
    chk("lw_cause", 32'(last_cause), 32'(ERR_OK));
    chk("lw_beat_addr", beats[0].a, 32'h100);
    clear(); plan(1'b0, FMT_B, 32'h103, '0, 32'h80123456, '0, 0, 0); run(-1);
    chk("lb_rd", a_if.core_read_data, 32'hFFFFFF80);
    chk("lb_be", 32'(beats[0].be), 32'h8);
    clear(); plan(1'b0, FMT_BU, 32'h103, '0, 32'h80123456, '0, 1, 0); run(-1);
    chk("lbu_rd", a_if.core_read_data, 32'h00000080);
    clear(); plan(1'b1, FMT_H, 32'h203, 32'h0000ABCD, '0, '0, 0, 0); run(-1);
    chk("sh_beats", 32'(beats.size()), 32'd2);
    chk("sh_lo_addr", beats[0].a, 32'h200);
    chk("sh_lo_be", 32'(beats[0].be), 32'h8);
    chk("sh_lo_wd", beats[0].wd, 32'hCD000000);
    chk("sh_hi_addr", beats[1].a, 32'h204);
    chk("sh_hi_be", 32'(beats[1].be), 32'h1);
    chk("sh_hi_wd", beats[1].wd, 32'h000000AB);
    chk("sh_done_count", 32'(n_done), 32'd1);
    chk("sh_rd_hold", a_if.core_read_data, 32'h00000080);
    clear(); plan(1'b0, FMT_W, 32'h101, '0, 32'h44332211, 32'h88776655, 1, 0); run(-1);
    chk("lw_split_rd", a_if.core_read_data, 32'h55443322);
    clear(); plan(1'b0, FMT_H, 32'h107, '0, 32'hAABBCCDD, 32'h112233F4, 0, 2); run(-1);
    chk("lh_split_rd", a_if.core_read_data, 32'hFFFFF4AA);
    plan(1'b0, FMT_HU, 32'h102, '0, 32'h8001_1234, '0, 2, 0); run(-1);
    plan(1'b1, FMT_B, 32'h301, 32'h12345678, '0, '0, 0, 0); run(-1);
    plan(1'b1, FMT_W, 32'hFFFF_FFFE, 32'hA1B2C3D4, '0, '0, 0, 1); run(-1);
    clear(); plan(1'b0, 3'b111, 32'h100, '0, '0, '0, 0, 0); run(-1);
    chk("illegal_cause", 32'(last_cause), 32'(ERR_FORMAT));
    chk("illegal_no_bus", 32'(beats.size()), 32'd0);
    clear(); plan(1'b0, FMT_W, 32'h100, '0, 32'h13579BDF, '0, T, 0); run(-1);
    chk("to_re_cycles", 32'(n_re), 32'd15);
    chk("to_cause", 32'(last_cause), 32'(ERR_TIMEOUT));
    clear(); plan(1'b0, FMT_W, 32'h100, '0, 32'h2468ACE0, '0, T - 1, 0); run(-1);
    chk("late_ready_re_cycles", 32'(n_re), 32'd15);
    chk("late_ready_cause", 32'(last_cause), 32'(ERR_OK));
    chk("late_ready_rd", a_if.core_read_data, 32'h2468ACE0);
    plan(1'b1, FMT_W, 32'h302, 32'h11223344, '0, '0, 0, 20); run(-1);
    clear(); plan(1'b1, FMT_W, 32'h302, 32'h11223344, '0, '0, 0, 5); run(3);
    @(negedge clk);
    rst = 1'b1; model_rd = '0; q.delete(); drive(idle());
    @(negedge clk);
    rst = 1'b0; drive(idle());
    #3;
    chk("rst_no_done", 32'(n_done), 32'd0);
    clear(); plan(1'b0, FMT_W, 32'h104, '0, 32'hCAFEF00D, '0, 0, 0); run(-1);
    chk("post_rst_rd", a_if.core_read_data, 32'hCAFEF00D);
    @(negedge clk);
    n_if.core_request = 1'b1; n_if.core_address = 32'h106; n_if.bus_ready = 1'b1;
    @(negedge clk);
    n_if.core_request = 1'b0;
    #2;
    chk("nm_done", 32'(n_if.core_done), 32'd1);
    chk("nm_cause", 32'(n_if.core_error_cause), 32'(ERR_MISALIGNED));
    chk("nm_no_enables", 32'({n_if.bus_read_enable, n_if.bus_write_enable}), 32'd0);
    @(negedge clk);
    #2;
    chk("nm_idle", 32'(n_if.core_busy), 32'd0);
    chk("nm_no_enables_after", 32'({n_if.bus_read_enable, n_if.bus_write_enable}), 32'd0);
    @(negedge clk);
    n_if.core_request = 1'b1; n_if.core_format = FMT_H; n_if.core_address = 32'h102; n_if.bus_read_data = 32'h8001_0000;
    @(negedge clk);
    n_if.core_request = 1'b0;
    #2;
    chk("nm_lh_re", 32'(n_if.bus_read_enable), 32'd1);
    chk("nm_lh_be", 32'(n_if.bus_byte_enable), 32'hC);
    @(negedge clk);
    #2;
    chk("nm_lh_done", 32'(n_if.core_done), 32'd1);
    chk("nm_lh_rd", n_if.core_read_data, 32'hFFFF8001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_memory_interface.md
Name: multicycle_memory_interface

Overview:
Data-side bus adapter for the multicycle core, placed between the datapath load/store port and the system bus. It generalises the single-cycle data memory interface in three ways: a variable-latency bus with a ready handshake, optional splitting of misaligned accesses into two word accesses, and a bounded bus timeout. Load results are extended to 32 bits and returned with a one-cycle done pulse, so the control path can stall on busy and advance on done.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two bus accesses; 0 = report a misaligned error with no bus activity.
TIMEOUT_CYCLES, 15, maximum cycles spent in one bus access before abort; 0 disables the timeout.

Ports:
clock  input  1  core clock; single clock domain.
reset  input  1  asynchronous, active-high reset.
core_request  input  1  start an access; sampled only in IDLE.
core_write  input  1  1 = store, 0 = load.
core_format  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
core_address  input  32  byte address.
core_write_data  input  32  store data, right-aligned.
core_read_data  output  32  extended load result; held until the next accepted request.
core_busy  output  1  high whenever state != IDLE.
core_done  output  1  one-cycle completion pulse.
core_error_cause  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal format; valid with core_done.
bus_address  output  32  word-aligned bus address.
bus_read_data  input  32  bus read word.
bus_write_data  output  32  lane-positioned write word.
bus_byte_enable  output  4  lane enables.
bus_read_enable  output  1  load access active.
bus_write_enable  output  1  store access active.
bus_ready  input  1  bus completes the current access at the clock edge where it is high.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0; latched request and timeout counter cleared.
- Bus outputs decode from state plus latched registers only; core inputs never reach the bus combinationally.
- States:
  - IDLE: on core_request, latch address, data, format and write.
    - Illegal format -> RESPOND, cause 11.
    - Misaligned (H at offset 3, W at offset != 0) with ALLOW_MISALIGNED=0 -> RESPOND, cause 01.
    - Otherwise -> ACCESS_LO.
  - ACCESS_LO: bus_address = {addr[31:2], 2'b00}.
    - byte_enable = (size_mask << off)[3:0], where size_mask is 0001, 0011 or 1111.
    - write_data = wdata << 8*off.
    - On bus_ready: capture the read word into lo; go to ACCESS_HI if (off + size) > 4, else RESPOND.
  - ACCESS_HI: bus_address = lo address + 4 (wraps mod 2^32).
    - byte_enable = size_mask >> (4 - off).
    - write_data = wdata >> 8*(4 - off).
    - On bus_ready: capture hi; go to RESPOND.
  - RESPOND: core_done = 1 for exactly one cycle; core_read_data updates in this same cycle; then IDLE.
- Read assembly: {hi, lo} >> 8*off, truncated to size, then sign-extended for B/H or zero-extended for BU/HU/W.
- Stores leave core_read_data unchanged.
- Timeout: a counter resets on entry to each ACCESS state.
  - An ACCESS state lasts at most TIMEOUT_CYCLES cycles without bus_ready.
  - On expiry: go to RESPOND with cause 10; the second half of a split access is not issued.
  - bus_ready in the final cycle wins over the timeout.
- Latency: request sampled at edge 0; with zero-wait ready, core_done is high in the second cycle after the request (aligned). Each bus wait cycle or split half adds 1 cycle.
- core_request while busy is ignored. The core must hold it low until done.
- Reset in any state aborts at once: no done pulse, enables drop in the same cycle.

Decomposition:
- Shared constants header gets:
  - data-format codes (B/H/W/BU/HU);
  - error-cause codes;
  - the state enum typedef (IDLE, ACCESS_LO, ACCESS_HI, RESPOND).
- One combinational sub-module, memory_lane_aligner, covers the size mask, enable and write-data shifting for the lo/hi halves, and read assembly plus extension.
- The FSM, counter and latches stay in the top module.

Test Plan:
- LW 0x100, bus_ready tied 1, bus_read_data 0xDEADBEEF -> one access at 0x100, enables 1111; done in the second cycle; read_data 0xDEADBEEF; cause 00.
- LB 0x103 with bus word 0x80123456 -> enables 1000, read_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH 0x203, data 0x0000ABCD, ALLOW_MISALIGNED=1:
  - first access: 0x200, enables 1000, write_data 0xCD000000;
  - second access: 0x204, enables 0001, write_data 0x000000AB;
  - then one done pulse.
- LW 0x106 with ALLOW_MISALIGNED=0 -> no read/write enable ever asserted; done with cause 01.
- LW 0x100, bus_ready held 0, TIMEOUT_CYCLES=15 -> read enable high exactly 15 cycles, then done with cause 10; a ready on cycle 15 instead completes with cause 00.
- Reset asserted during ACCESS_HI of a split store -> enables 0 before the next edge; busy 0; no done pulse; the next request behaves normally.
